// File: rtl/vga_game_pkg.sv
// -----------------------------------------------------------------------------
// vga_game_pkg
// Shared definitions for the circle sprite motion controller:
//   - state_t      : motion FSM states (IDLE, WAIT, STEP_X, STEP_Y, COMMIT)
//   - DEF_*        : default screen geometry and sprite size
//   - vel_mag()    : magnitude of an 8-bit two's-complement velocity
// No ports (package).
// -----------------------------------------------------------------------------
package vga_game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    STEP_X = 3'd2,
    STEP_Y = 3'd3,
    COMMIT = 3'd4
  } state_t;

  localparam int DEF_SCREEN_WIDTH  = 800;
  localparam int DEF_SCREEN_HEIGHT = 600;
  localparam int DEF_OBJ_SIZE      = 32;

  // |v| for an 8-bit signed velocity; -128 never occurs because |v| < OBJ_SIZE.
  function automatic logic [7:0] vel_mag(input logic [7:0] v);
    logic [7:0] m;
    if (v[7]) begin
      m = 8'd0 - v;
    end else begin
      m = v;
    end
    return m;
  endfunction

endpackage

// File: rtl/circ_axis_step.sv
// -----------------------------------------------------------------------------
// circ_axis_step
// One-axis position update for the sprite: adds the signed velocity to the
// position, clamps against [0, LIMIT] and reflects the velocity on a hit.
// Purely combinational; the caller registers the results.
//
// Optional feature macro: CIRC_SPEEDUP_EN
//   defined     : a reflection also grows |v| by 1, saturating at MAX_SPEED
//   not defined : a reflection only negates v
//
// Parameters
//   LIMIT      largest legal top-left coordinate (screen extent - sprite size)
//   MAX_SPEED  |v| ceiling for the speed-up feature
// Ports
//   pos       in   16  current working coordinate
//   vel       in    8  current signed velocity
//   next_pos  out  16  coordinate after this step
//   next_vel  out   8  velocity after this step
//   hit       out   1  a reflection happened on this step
// -----------------------------------------------------------------------------
module circ_axis_step
  import vga_game_pkg::*;
#(
  parameter int LIMIT     = 768,
  parameter int MAX_SPEED = 8
) (
  input  logic [15:0] pos,
  input  logic [7:0]  vel,
  output logic [15:0] next_pos,
  output logic [7:0]  next_vel,
  output logic        hit
);

  localparam logic signed [16:0] LIMIT_S = 17'(LIMIT);
  localparam logic [15:0]        LIMIT_P = 16'(LIMIT);
  localparam logic [7:0]         MAX_MAG = 8'(MAX_SPEED);

`ifdef CIRC_SPEEDUP_EN
  localparam logic SPEEDUP = 1'b1;
`else
  localparam logic SPEEDUP = 1'b0;
`endif

  logic signed [16:0] sum;
  logic [7:0]         mag;
  logic [7:0]         mag_up;
  logic [7:0]         plain_vel;
  logic [7:0]         fast_vel;

  // 17-bit signed candidate position: zero-extended pos plus sign-extended vel.
  always_comb begin
    sum = $signed({1'b0, pos}) + $signed({{9{vel[7]}}, vel});
  end

  // Both reflection flavours; the opposite sign of the incoming velocity is
  // always the outgoing direction, whichever wall was hit.
  always_comb begin
    mag = vel_mag(vel);
    if (mag >= MAX_MAG) begin
      mag_up = MAX_MAG;
    end else begin
      mag_up = mag + 8'd1;
    end
    plain_vel = 8'd0 - vel;
    if (vel[7]) begin
      fast_vel = mag_up;
    end else begin
      fast_vel = 8'd0 - mag_up;
    end
  end

  // Clamp against the two walls; landing exactly on a wall is not a hit.
  always_comb begin
    hit      = 1'b0;
    next_pos = pos;
    if (sum < 17'sd0) begin
      next_pos = 16'd0;
      hit      = 1'b1;
    end else if (sum > LIMIT_S) begin
      next_pos = LIMIT_P;
      hit      = 1'b1;
    end else begin
      next_pos = sum[15:0];
    end
  end

  // Velocity out: unchanged unless reflected.
  always_comb begin
    next_vel = vel;
    if (hit) begin
      next_vel = SPEEDUP ? fast_vel : plain_vel;
    end else begin
      next_vel = vel;
    end
  end

endmodule

// File: rtl/circ_motion_ctrl.sv
// -----------------------------------------------------------------------------
// circ_motion_ctrl
// Owns the bouncing ball position for the circle sprite overlay. Once per
// video frame (at the start of vertical blank) it steps x then y by a signed
// velocity, reflecting off the screen edges, and publishes the new
// coordinates in a single COMMIT cycle so the overlay never tears.
//
// Optional feature macro: CIRC_SPEEDUP_EN (handled in circ_axis_step)
//   each reflection also grows |v| on that axis by 1, up to MAX_SPEED.
//
// Ports
//   clk         in   1   pixel clock
//   rstn        in   1   asynchronous active-low reset
//   hst         in  11   horizontal counter from VGA timing
//   vst         in  10   vertical counter from VGA timing
//   run         in   1   1 = motion enabled, 0 = freeze position
//   restart     in   1   synchronous reload of the INIT_* values (top priority)
//   block_posx  out 16   published sprite x (top-left)
//   block_posy  out 16   published sprite y (top-left)
//   bounce_x    out  1   pulse in the COMMIT result cycle on an x reflection
//   bounce_y    out  1   pulse in the COMMIT result cycle on a y reflection
//   frame_tick  out  1   pulse at the start of each vertical blank
// -----------------------------------------------------------------------------
module circ_motion_ctrl
  import vga_game_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int OBJ_SIZE      = DEF_OBJ_SIZE,
  parameter int INIT_X        = 384,
  parameter int INIT_Y        = 284,
  parameter int INIT_VX       = 2,
  parameter int INIT_VY       = 1,
  parameter int MAX_SPEED     = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [10:0] hst,
  input  logic [9:0]  vst,
  input  logic        run,
  input  logic        restart,
  output logic [15:0] block_posx,
  output logic [15:0] block_posy,
  output logic        bounce_x,
  output logic        bounce_y,
  output logic        frame_tick
);

  localparam logic [15:0] INIT_X_V  = 16'(INIT_X);
  localparam logic [15:0] INIT_Y_V  = 16'(INIT_Y);
  localparam logic [7:0]  INIT_VX_V = 8'(INIT_VX);
  localparam logic [7:0]  INIT_VY_V = 8'(INIT_VY);
  localparam logic [9:0]  BLANK_LINE = 10'(SCREEN_HEIGHT);

  state_t      state;
  state_t      next_state;

  logic [15:0] pos_x;
  logic [15:0] pos_y;
  logic [7:0]  vel_x;
  logic [7:0]  vel_y;
  logic        flag_x;
  logic        flag_y;

  logic [15:0] step_pos_x;
  logic [15:0] step_pos_y;
  logic [7:0]  step_vel_x;
  logic [7:0]  step_vel_y;
  logic        hit_x;
  logic        hit_y;

  logic        blank_start;

  // First pixel of the first blanking line marks the frame boundary.
  always_comb begin
    blank_start = (hst == 11'd0) && (vst == BLANK_LINE);
  end

  // Registered frame boundary pulse; follows the video timing only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= blank_start;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; once STEP_X is entered the step runs to COMMIT
  // regardless of run, so only restart can abandon it.
  always_comb begin
    next_state = state;
    if (restart) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            next_state = WAIT;
          end else begin
            next_state = IDLE;
          end
        end
        WAIT: begin
          if (frame_tick && run) begin
            next_state = STEP_X;
          end else begin
            next_state = WAIT;
          end
        end
        STEP_X:  next_state = STEP_Y;
        STEP_Y:  next_state = COMMIT;
        COMMIT:  next_state = WAIT;
        default: next_state = IDLE;
      endcase
    end
  end

  circ_axis_step #(
    .LIMIT     (SCREEN_WIDTH - OBJ_SIZE),
    .MAX_SPEED (MAX_SPEED)
  ) u_step_x (
    .pos      (pos_x),
    .vel      (vel_x),
    .next_pos (step_pos_x),
    .next_vel (step_vel_x),
    .hit      (hit_x)
  );

  circ_axis_step #(
    .LIMIT     (SCREEN_HEIGHT - OBJ_SIZE),
    .MAX_SPEED (MAX_SPEED)
  ) u_step_y (
    .pos      (pos_y),
    .vel      (vel_y),
    .next_pos (step_pos_y),
    .next_vel (step_vel_y),
    .hit      (hit_y)
  );

  // Working position/velocity and per-axis hit flags, one axis per step state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos_x  <= INIT_X_V;
      pos_y  <= INIT_Y_V;
      vel_x  <= INIT_VX_V;
      vel_y  <= INIT_VY_V;
      flag_x <= 1'b0;
      flag_y <= 1'b0;
    end else if (restart) begin
      pos_x  <= INIT_X_V;
      pos_y  <= INIT_Y_V;
      vel_x  <= INIT_VX_V;
      vel_y  <= INIT_VY_V;
      flag_x <= 1'b0;
      flag_y <= 1'b0;
    end else begin
      case (state)
        STEP_X: begin
          pos_x  <= step_pos_x;
          vel_x  <= step_vel_x;
          flag_x <= hit_x;
        end
        STEP_Y: begin
          pos_y  <= step_pos_y;
          vel_y  <= step_vel_y;
          flag_y <= hit_y;
        end
        default: begin
          pos_x  <= pos_x;
          pos_y  <= pos_y;
          vel_x  <= vel_x;
          vel_y  <= vel_y;
          flag_x <= flag_x;
          flag_y <= flag_y;
        end
      endcase
    end
  end

  // Published outputs: coordinates move and bounce pulses fire only in COMMIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      block_posx <= INIT_X_V;
      block_posy <= INIT_Y_V;
      bounce_x   <= 1'b0;
      bounce_y   <= 1'b0;
    end else if (restart) begin
      block_posx <= INIT_X_V;
      block_posy <= INIT_Y_V;
      bounce_x   <= 1'b0;
      bounce_y   <= 1'b0;
    end else begin
      case (state)
        COMMIT: begin
          block_posx <= pos_x;
          block_posy <= pos_y;
          bounce_x   <= flag_x;
          bounce_y   <= flag_y;
        end
        default: begin
          block_posx <= block_posx;
          block_posy <= block_posy;
          bounce_x   <= 1'b0;
          bounce_y   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_circ_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_circ_motion_ctrl
// Randomized frame-level bench for circ_motion_ctrl. Video timing is
// compressed: the blank-start condition (hst==0, vst==600) is presented for a
// single cycle per frame, all other cycles carry random non-matching counts.
// A per-frame model of the ball (position, velocity, armed/idle) predicts the
// published outputs. Honors CIRC_SPEEDUP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_circ_motion_ctrl;

  localparam int LIM_X = 800 - 32;
  localparam int LIM_Y = 600 - 32;
  localparam int MAXV  = 8;
  localparam int NFR   = 1500;

  logic        clk = 1'b0;
  logic        rstn;
  logic [10:0] hst;
  logic [9:0]  vst;
  logic        run;
  logic        restart;
  logic [15:0] block_posx;
  logic [15:0] block_posy;
  logic        bounce_x;
  logic        bounce_y;
  logic        frame_tick;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference state
  int m_x, m_y, m_vx, m_vy;
  bit m_active;

  circ_motion_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .hst        (hst),
    .vst        (vst),
    .run        (run),
    .restart    (restart),
    .block_posx (block_posx),
    .block_posy (block_posy),
    .bounce_x   (bounce_x),
    .bounce_y   (bounce_y),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL timeout: bench did not complete (vectors %0d)", vec_cnt);
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input int exp);
    vec_cnt++;
    if (got !== 32'(exp)) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int reflect_v(input int v);
`ifdef CIRC_SPEEDUP_EN
    int mag;
    mag = (v < 0) ? -v : v;
    mag = mag + 1;
    if (mag > MAXV) mag = MAXV;
    return (v < 0) ? mag : -mag;
`else
    return -v;
`endif
  endfunction

  task automatic move_axis(input int p, input int v, input int lim,
                           output int np, output int nv, output bit hit);
    int n;
    n   = p + v;
    hit = 1'b0;
    if (n < 0) begin
      np = 0; hit = 1'b1;
    end else if (n > lim) begin
      np = lim; hit = 1'b1;
    end else begin
      np = n;
    end
    nv = hit ? reflect_v(v) : v;
  endtask

  task automatic model_init();
    m_x = 384; m_y = 284; m_vx = 2; m_vy = 1; m_active = 1'b0;
  endtask

  // Advance one clock and put random non-blank timing on the bus.
  task automatic step_cycle();
    @(posedge clk);
    #1;
    if ($urandom_range(0, 3) == 0) begin
      hst = 11'd0;
      vst = 10'($urandom_range(0, 599));
    end else begin
      hst = 11'($urandom_range(1, 1999));
      vst = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic run_frame(input int f);
    bit run_v, do_step, mid_rst, hx, hy;
    int nx, nvx, ny, nvy;

    if (f > 0 && $urandom_range(0, 899) == 0) begin
      restart = 1'b1;
      step_cycle();
      restart = 1'b0;
      model_init();
      check_val("restart_x", block_posx, m_x);
      check_val("restart_y", block_posy, m_y);
    end

    run_v = (f < 4) ? 1'b1 : ($urandom_range(0, 7) != 0);
    run   = run_v;
    step_cycle();
    step_cycle();
    if (run_v) m_active = 1'b1;

    hst = 11'd0;
    vst = 10'd600;
    step_cycle();
    check_val("tick_hi", frame_tick, 1);
    do_step = m_active && run_v;
    step_cycle();
    check_val("tick_lo", frame_tick, 0);
    if ($urandom_range(0, 3) == 0) run = 1'b0;   // drop run mid-step
    mid_rst = (f == 3) || (f == 1000) || ($urandom_range(0, 899) == 0);
    step_cycle();
    if (mid_rst) restart = 1'b1;
    step_cycle();
    restart = 1'b0;
    if (mid_rst) begin
      run = 1'b0;
      model_init();
    end
    // Latency: nothing published yet
    check_val("hold_x", block_posx, m_x);
    check_val("hold_y", block_posy, m_y);
    check_val("hold_bx", bounce_x, 0);
    check_val("hold_by", bounce_y, 0);
    step_cycle();
    hx = 1'b0;
    hy = 1'b0;
    if (do_step && !mid_rst) begin
      move_axis(m_x, m_vx, LIM_X, nx, nvx, hx);
      move_axis(m_y, m_vy, LIM_Y, ny, nvy, hy);
      m_x = nx; m_vx = nvx; m_y = ny; m_vy = nvy;
    end
    check_val("posx", block_posx, m_x);
    check_val("posy", block_posy, m_y);
    check_val("bounce_x", bounce_x, int'(hx));
    check_val("bounce_y", bounce_y, int'(hy));
    step_cycle();
    check_val("bx_pulse_end", bounce_x, 0);
    check_val("by_pulse_end", bounce_y, 0);
    repeat ($urandom_range(0, 3)) step_cycle();
  endtask

  initial begin
    rstn    = 1'b0;
    hst     = 11'd1;
    vst     = 10'd0;
    run     = 1'b0;
    restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    step_cycle();
    model_init();
    check_val("rst_posx", block_posx, 384);
    check_val("rst_posy", block_posy, 284);
    check_val("rst_bx", bounce_x, 0);
    check_val("rst_by", bounce_y, 0);
    check_val("rst_tick", frame_tick, 0);

    for (int f = 0; f < NFR; f++) begin
      run_frame(f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
